// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag/abort detection, zero removal and LSB-first byte assembly.
// Optional FCS check (CRC-16-CCITT residue) is built when HDLC_RX_FCS_EN is defined.
`timescale 1ns/1ps

module hdlc_rx_deframer #(
  parameter int unsigned MAX_BYTES  = 128,
  parameter int unsigned STUFF_ONES = 5
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  input  logic       RxEN,
  input  logic       Rx_FCSen,
  output logic [7:0] Rx_Data,
  output logic       Rx_NewByte,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_ValidFrame,
  output logic       Rx_AbortSignal,
  output logic       Rx_EoF,
  output logic       Rx_FrameError,
  output logic       Rx_Overflow,
  output logic       Rx_FCSerr
);

  typedef enum logic {S_IDLE, S_FRAME} state_t;

  localparam logic [7:0] LP_FLAG  = 8'h7E;
  localparam logic [7:0] LP_ABORT = 8'hFE;   // oldest bit (0) sits in r_win[0]
  localparam logic [7:0] LP_STUFF = 8'(STUFF_ONES);

  state_t      r_state;
  logic [7:0]  r_win;
  logic [7:0]  r_mask;
  logic [7:0]  r_ones;
  logic [6:0]  r_shift;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_bytecnt;
  logic        r_vf_d;
  logic        r_close_err;

  logic        w_flag;
  logic        w_abort;
  logic        w_bit;
  logic        w_exit;
  logic        w_drop;
  logic        w_keep;

  assign w_flag  = (r_win == LP_FLAG);
  assign w_abort = (r_win == LP_ABORT) && !w_flag;
  assign w_bit   = r_win[0];
  // The flag itself must never leave the window into byte assembly.
  assign w_exit  = r_mask[0] && (r_state == S_FRAME) && !w_flag;
  assign w_drop  = w_exit && !w_bit && (r_ones == LP_STUFF);
  assign w_keep  = w_exit && !w_drop;

`ifdef HDLC_RX_FCS_EN
  logic [15:0] r_crc;
  logic        r_fcs_err;
  logic [15:0] w_crc_next;
  logic        w_fcs_bad;

  assign w_crc_next = {1'b0, r_crc[15:1]} ^ ((r_crc[0] ^ w_bit) ? 16'h8408 : 16'h0000);
  assign w_fcs_bad  = (r_bitcnt == 3'd0) && Rx_FCSen && (r_crc != 16'hF0B8);
`else
  logic w_unused_fcsen;
  assign w_unused_fcsen = Rx_FCSen;
  assign Rx_FCSerr      = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst || !RxEN) begin
      r_state        <= S_IDLE;
      r_win          <= '0;
      r_mask         <= '0;
      r_ones         <= '0;
      r_shift        <= '0;
      r_bitcnt       <= '0;
      r_bytecnt      <= '0;
      r_vf_d         <= 1'b0;
      r_close_err    <= 1'b0;
      Rx_Data        <= '0;
      Rx_NewByte     <= 1'b0;
      Rx_FlagDetect  <= 1'b0;
      Rx_AbortDetect <= 1'b0;
      Rx_ValidFrame  <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;
      Rx_Overflow    <= 1'b0;
`ifdef HDLC_RX_FCS_EN
      r_crc          <= '1;
      r_fcs_err      <= 1'b0;
      Rx_FCSerr      <= 1'b0;
`endif
    end else begin
      Rx_NewByte     <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_FrameError  <= 1'b0;
`ifdef HDLC_RX_FCS_EN
      Rx_FCSerr      <= 1'b0;
`endif

      r_win          <= {Rx, r_win[7:1]};
      r_mask         <= w_flag ? 8'h80 : {1'b1, r_mask[7:1]};
      Rx_FlagDetect  <= w_flag;
      Rx_AbortDetect <= w_abort;

      if (w_exit) begin
        if (!w_bit)
          r_ones <= '0;
        else if (r_ones != 8'hFF)
          r_ones <= r_ones + 8'd1;
      end

      if (w_keep) begin
        r_shift  <= {w_bit, r_shift[6:1]};
        r_bitcnt <= r_bitcnt + 3'd1;
`ifdef HDLC_RX_FCS_EN
        r_crc    <= w_crc_next;
`endif
        if (r_bitcnt == 3'd7) begin
          Rx_Data    <= {w_bit, r_shift};
          Rx_NewByte <= 1'b1;
          if (r_bytecnt != 8'hFF)
            r_bytecnt <= r_bytecnt + 8'd1;
        end
      end

      r_vf_d <= Rx_ValidFrame;
      if (r_state == S_IDLE) begin
        if (Rx_FlagDetect) begin
          r_state       <= S_FRAME;
          Rx_ValidFrame <= 1'b1;
          r_bitcnt      <= '0;
          r_bytecnt     <= '0;
          r_ones        <= '0;
          r_close_err   <= 1'b0;
`ifdef HDLC_RX_FCS_EN
          r_crc         <= '1;
          r_fcs_err     <= 1'b0;
`endif
        end
      end else begin
        if (Rx_FlagDetect) begin
          // An empty frame between two flags is just flag fill.
          if ((r_bytecnt != 8'd0) || (r_bitcnt != 3'd0)) begin
            r_state       <= S_IDLE;
            Rx_ValidFrame <= 1'b0;
`ifdef HDLC_RX_FCS_EN
            r_close_err   <= (r_bitcnt != 3'd0) || w_fcs_bad;
            r_fcs_err     <= w_fcs_bad;
`else
            r_close_err   <= (r_bitcnt != 3'd0);
`endif
          end
        end else if (Rx_AbortDetect) begin
          r_state        <= S_IDLE;
          Rx_ValidFrame  <= 1'b0;
          Rx_AbortSignal <= 1'b1;
          r_close_err    <= 1'b0;
`ifdef HDLC_RX_FCS_EN
          r_fcs_err      <= 1'b0;
`endif
        end
      end

      if (r_vf_d && !Rx_ValidFrame) begin
        Rx_EoF        <= 1'b1;
        Rx_FrameError <= r_close_err;
`ifdef HDLC_RX_FCS_EN
        Rx_FCSerr     <= r_fcs_err;
`endif
      end

      // Overflow stays visible during the Rx_EoF cycle, then clears.
      if (Rx_EoF)
        Rx_Overflow <= 1'b0;
      else if (Rx_NewByte && (32'(r_bytecnt) > MAX_BYTES))
        Rx_Overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Scoreboard bench for hdlc_rx_deframer: bytes pushed when driven, popped on Rx_NewByte.
`timescale 1ns/1ps

module tb_hdlc_rx_deframer;

  localparam int unsigned MAXB = 128;

  logic       Clk = 1'b0;
  logic       Rst, Rx, RxEN, Rx_FCSen;
  logic [7:0] Rx_Data;
  logic       Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame;
  logic       Rx_AbortSignal, Rx_EoF, Rx_FrameError, Rx_Overflow, Rx_FCSerr;

  always #5 Clk = ~Clk;

  hdlc_rx_deframer #(.MAX_BYTES(MAXB), .STUFF_ONES(5)) u_dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx), .RxEN(RxEN), .Rx_FCSen(Rx_FCSen),
    .Rx_Data(Rx_Data), .Rx_NewByte(Rx_NewByte), .Rx_FlagDetect(Rx_FlagDetect),
    .Rx_AbortDetect(Rx_AbortDetect), .Rx_ValidFrame(Rx_ValidFrame),
    .Rx_AbortSignal(Rx_AbortSignal), .Rx_EoF(Rx_EoF), .Rx_FrameError(Rx_FrameError),
    .Rx_Overflow(Rx_Overflow), .Rx_FCSerr(Rx_FCSerr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] sb_q[$];

  int edge_n = 0;
  int flag_edge = -1, abd_edge = -1, abs_edge = -1;
  int vf_rise_edge = -1, vf_fall_edge = -1, eof_edge = -1;
  int ov_rise_edge = -1, ov_fall_edge = -1, nb_ov_edge = -1;
  int abd_cnt = 0, abs_cnt = 0, vf_rise_cnt = 0, eof_cnt = 0, nb_cnt = 0, ov_rise_cnt = 0;
  int nb_in_frame = 0;
  logic ferr_at_eof = 1'b0, fcserr_at_eof = 1'b0;
  logic vf_prev = 1'b0, ov_prev = 1'b0;

  // Monitor samples 1 ns after each rising edge; edge_n numbers that edge.
  always begin
    logic [7:0] exp_b;
    @(posedge Clk);
    #1;
    edge_n++;
    if (Rx_FlagDetect) flag_edge = edge_n;
    if (Rx_AbortDetect) begin abd_edge = edge_n; abd_cnt++; end
    if (Rx_AbortSignal) begin abs_edge = edge_n; abs_cnt++; end
    if (Rx_ValidFrame && !vf_prev) begin vf_rise_edge = edge_n; vf_rise_cnt++; nb_in_frame = 0; end
    if (!Rx_ValidFrame && vf_prev) vf_fall_edge = edge_n;
    vf_prev = Rx_ValidFrame;
    if (Rx_NewByte) begin
      nb_cnt++;
      nb_in_frame++;
      if (nb_in_frame == int'(MAXB) + 1) nb_ov_edge = edge_n;
      check_val("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_b = sb_q.pop_front();
        check_val("rx_data", 32'(Rx_Data), 32'(exp_b));
      end
    end
    if (Rx_EoF) begin
      eof_edge = edge_n;
      eof_cnt++;
      ferr_at_eof = Rx_FrameError;
      fcserr_at_eof = Rx_FCSerr;
    end
    if (Rx_Overflow && !ov_prev) begin ov_rise_edge = edge_n; ov_rise_cnt++; end
    if (!Rx_Overflow && ov_prev) ov_fall_edge = edge_n;
    ov_prev = Rx_Overflow;
  end

  int last_bit_edge = 0;
  int st_ones = 0;

  task automatic send_bit(input logic b);
    @(negedge Clk);
    Rx = b;
    last_bit_edge = edge_n + 1;
  endtask

  task automatic send_raw8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    st_ones = 0;
  endtask

  task automatic send_dbit(input logic b);
    send_bit(b);
    if (b) begin
      st_ones++;
      if (st_ones == 5) begin
        send_bit(1'b0);
        st_ones = 0;
      end
    end else begin
      st_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input logic push);
    for (int i = 0; i < 8; i++) send_dbit(v[i]);
    if (push) sb_q.push_back(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  function automatic logic [15:0] crc16(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] c;
    logic [15:0] d;
    logic        fb;
    c = 16'hFFFF;
    d = {b, a};
    for (int i = 0; i < 16; i++) begin
      fb = c[0] ^ d[i];
      c  = {1'b0, c[15:1]};
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int e0, a0, s0, v0, n0, o0;
    logic [15:0] fcs;

    Rst = 1'b1; RxEN = 1'b1; Rx = 1'b1; Rx_FCSen = 1'b0;
    repeat (3) @(negedge Clk);
    check_val("rst_data",   32'(Rx_Data), 32'd0);
    check_val("rst_nb",     32'(Rx_NewByte), 32'd0);
    check_val("rst_flag",   32'(Rx_FlagDetect), 32'd0);
    check_val("rst_abd",    32'(Rx_AbortDetect), 32'd0);
    check_val("rst_vf",     32'(Rx_ValidFrame), 32'd0);
    check_val("rst_abs",    32'(Rx_AbortSignal), 32'd0);
    check_val("rst_eof",    32'(Rx_EoF), 32'd0);
    check_val("rst_ferr",   32'(Rx_FrameError), 32'd0);
    check_val("rst_ov",     32'(Rx_Overflow), 32'd0);
    check_val("rst_fcserr", 32'(Rx_FCSerr), 32'd0);
    Rst = 1'b0;

    // Opening flag after long idle, then A5/3C frame
    idle(50);
    send_raw8(8'h7E);
    t = last_bit_edge;
    send_byte(8'hA5, 1'b1);
    check_val("flag_latency", flag_edge, t + 1);
    check_val("vf_rise",      vf_rise_edge, t + 2);
    check_val("no_nb_early",  nb_cnt, 0);
    e0 = eof_cnt; a0 = abd_cnt; s0 = abs_cnt;
    send_byte(8'h3C, 1'b1);
    send_raw8(8'h7E);
    t = last_bit_edge;
    idle(12);
    check_val("close_vf_fall", vf_fall_edge, t + 2);
    check_val("close_eof",     eof_edge, t + 3);
    check_val("close_eof_cnt", eof_cnt, e0 + 1);
    check_val("close_ferr",    32'(ferr_at_eof), 32'd0);
    check_val("close_nb_cnt",  nb_cnt, 2);
    check_val("idle_abort_det", abd_edge, t + 8);
    check_val("idle_abort_cnt", abd_cnt, a0 + 1);
    check_val("idle_no_abs",   abs_cnt, s0);

    // Stuffed zeros removed
    n0 = nb_cnt; e0 = eof_cnt;
    send_raw8(8'h7E);
    send_byte(8'h1F, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_raw8(8'h7E);
    idle(12);
    check_val("stuff_nb_cnt", nb_cnt, n0 + 2);
    check_val("stuff_eof",    eof_cnt, e0 + 1);
    check_val("stuff_ferr",   32'(ferr_at_eof), 32'd0);

    // Abort mid-frame
    e0 = eof_cnt; s0 = abs_cnt;
    send_raw8(8'h7E);
    send_byte(8'h55, 1'b1);
    send_raw8(8'hFE);
    t = last_bit_edge;
    idle(12);
    check_val("abort_det",    abd_edge, t + 1);
    check_val("abort_sig",    abs_edge, t + 2);
    check_val("abort_sig_n",  abs_cnt, s0 + 1);
    check_val("abort_vf",     vf_fall_edge, t + 2);
    check_val("abort_eof",    eof_edge, t + 3);
    check_val("abort_eof_n",  eof_cnt, e0 + 1);

    // Non-aligned close: 12 data bits
    e0 = eof_cnt;
    send_raw8(8'h7E);
    send_byte(8'h55, 1'b1);
    send_dbit(1'b1); send_dbit(1'b0); send_dbit(1'b1); send_dbit(1'b0);
    send_raw8(8'h7E);
    idle(12);
    check_val("odd_eof_n", eof_cnt, e0 + 1);
    check_val("odd_ferr",  32'(ferr_at_eof), 32'd1);

    // Back-to-back flags open a single frame
    e0 = eof_cnt; v0 = vf_rise_cnt;
    send_raw8(8'h7E);
    send_raw8(8'h7E);
    send_byte(8'h42, 1'b1);
    send_raw8(8'h7E);
    idle(12);
    check_val("b2b_vf_rise", vf_rise_cnt, v0 + 1);
    check_val("b2b_eof_n",   eof_cnt, e0 + 1);
    check_val("b2b_ferr",    32'(ferr_at_eof), 32'd0);

    // Exactly MAXB bytes: no overflow
    o0 = ov_rise_cnt;
    send_raw8(8'h7E);
    for (int i = 0; i < int'(MAXB); i++) send_byte(8'(i * 3 + 1), 1'b1);
    send_raw8(8'h7E);
    idle(12);
    check_val("max_no_ov", ov_rise_cnt, o0);

    // MAXB+1 bytes: overflow
    send_raw8(8'h7E);
    for (int i = 0; i <= int'(MAXB); i++) send_byte(8'(i * 7), 1'b1);
    send_raw8(8'h7E);
    idle(12);
    check_val("ov_rise_n",   ov_rise_cnt, o0 + 1);
    check_val("ov_rise",     ov_rise_edge, nb_ov_edge + 1);
    check_val("ov_clear",    ov_fall_edge, eof_edge + 1);
    check_val("ov_sb_empty", sb_q.size(), 0);

    // FCS frames: good then corrupted
    Rx_FCSen = 1'b1;
    fcs = ~crc16(8'h12, 8'h34);
    send_raw8(8'h7E);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(fcs[7:0], 1'b1);
    send_byte(fcs[15:8], 1'b1);
    send_raw8(8'h7E);
    idle(12);
    check_val("fcs_good_err",  32'(fcserr_at_eof), 32'd0);
    check_val("fcs_good_ferr", 32'(ferr_at_eof), 32'd0);
    fcs = fcs ^ 16'h0001;
    send_raw8(8'h7E);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(fcs[7:0], 1'b1);
    send_byte(fcs[15:8], 1'b1);
    send_raw8(8'h7E);
    idle(12);
`ifdef HDLC_RX_FCS_EN
    check_val("fcs_bad_err",  32'(fcserr_at_eof), 32'd1);
    check_val("fcs_bad_ferr", 32'(ferr_at_eof), 32'd1);
`else
    check_val("fcs_bad_err",  32'(fcserr_at_eof), 32'd0);
    check_val("fcs_bad_ferr", 32'(ferr_at_eof), 32'd0);
`endif
    Rx_FCSen = 1'b0;

    // RxEN drop mid-frame flushes without EoF
    e0 = eof_cnt;
    send_raw8(8'h7E);
    send_byte(8'h33, 1'b0);
    check_val("flush_vf_before", 32'(Rx_ValidFrame), 32'd1);
    @(negedge Clk);
    RxEN = 1'b0;
    @(negedge Clk);
    check_val("flush_vf", 32'(Rx_ValidFrame), 32'd0);
    repeat (5) @(negedge Clk);
    check_val("flush_no_eof", eof_cnt, e0);
    RxEN = 1'b1;
    idle(20);
    check_val("flush_no_eof_after", eof_cnt, e0);

    check_val("sb_empty_end", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
